div_ctrl: RTL and testbench
===========================

# div_ctrl

Programmable tick controller that sequences a free-running prescaler counter into a gated, configurable divide-by-N enable stream. Software or an upstream FSM loads a divide value and a tick count over a valid/ready config port. It then starts, stops (and optionally pauses) the block. It emits single-cycle `tick_o` enables to downstream slow-rate logic, either continuously (periodic) or for a fixed number of ticks (burst), with a `done_o` pulse at burst end.

## Interface
- `WIDTH`, 32: prescaler/divide-value width.
- `CNT_W`, 16: tick-count width (burst length and `tick_cnt_o`).
- `clk_i` in 1: sole clock, all logic on rising edge.
- `rstn_i` in 1: reset, synchronous, active-low.
- `cfg_valid_i` in 1: config offer.
- `cfg_ready_o` out 1: config accepted when `cfg_valid_i && cfg_ready_o`.
- `cfg_div_i` in WIDTH: divide value D; tick period = D+1 cycles.
- `cfg_cnt_i` in CNT_W: burst length N (ignored in periodic mode).
- `cfg_mode_i` in 1: 0 = periodic, 1 = burst.
- `start_i` in 1: start request.
- `stop_i` in 1: abort request.
- `tick_o` out 1: one-cycle enable pulse.
- `busy_o` out 1: high in RUN (and PAUSE).
- `done_o` out 1: one-cycle pulse at burst completion.
- `tick_cnt_o` out CNT_W: ticks emitted since last start.

## Operation
- States: IDLE, RUN, DONE (plus PAUSE, see Configuration).
- Reset: state IDLE, prescaler 0, stored D/N/mode 0, `tick_o`=0, `done_o`=0, `busy_o`=0, `cfg_ready_o`=1, `tick_cnt_o`=0. Reset mid-run aborts immediately with no `done_o`.
- `cfg_ready_o` = 1 only in IDLE. Config offered in RUN/DONE stalls and is not captured.
- IDLE: a handshake captures D, N and mode. When `start_i` is high, go to RUN, clear the prescaler and `tick_cnt_o`. If a handshake and `start_i` occur in the same cycle, the run uses the newly captured config.
- Burst with N=0: `start_i` goes straight to DONE with no ticks.
- RUN: the prescaler increments each cycle. `tick_o` = (state==RUN && prescaler==D). It is decoded from registers only, with no input-to-output path. At prescaler==D the prescaler wraps to 0 and `tick_cnt_o` increments, wrapping modulo 2^CNT_W.
- Burst mode: on the tick that makes `tick_cnt_o`==N, go to DONE.
- Periodic mode: run until `stop_i`.
- DONE: `done_o`=1 for exactly one cycle, then IDLE. `tick_cnt_o` holds its value until the next start.
- `stop_i` in RUN: go to IDLE next cycle with no `done_o`. A tick already decoded in the same cycle still appears. `stop_i` has priority over a burst completing on the same edge, so IDLE is entered, not DONE.
- `start_i` outside IDLE is ignored. `stop_i` in IDLE/DONE is ignored.
- D=0 gives a tick every RUN cycle.

## Timing
- `start_i` sampled at edge t: RUN from cycle t+1 with prescaler 0.
- First tick in cycle t+1+D. The k-th tick (k from 0) is in cycle t+1+D+k(D+1).
- Burst: last tick in cycle t+N(D+1). `done_o` in cycle t+N(D+1)+1. `cfg_ready_o` is high from t+N(D+1)+2.
- `stop_i` sampled at edge s: `busy_o`=0 and `tick_o`=0 from cycle s+1.
- All outputs are registered or decoded from registers.

## Configuration
- Macro `DIV_CTRL_PAUSE_EN`.
- Defined: adds port `pause_i` (in, 1) and state PAUSE.
  - In RUN with `pause_i`=1: go to PAUSE next cycle. The prescaler and `tick_cnt_o` freeze, and `tick_o`=0 while in PAUSE.
  - `pause_i`=0 returns to RUN and resumes from the frozen prescaler value, so period phase is preserved.
  - `stop_i` in PAUSE goes to IDLE.
  - `busy_o` stays 1 in PAUSE.
- Undefined: no `pause_i` port, no PAUSE state, behaviour exactly as above.

## Structure
- Package `div_ctrl_pkg`: state enum `div_state_e` {IDLE, RUN, PAUSE, DONE}; mode constants `MODE_PERIODIC`=1'b0, `MODE_BURST`=1'b1.
- Sub-module `div_ctrl_prescaler`: WIDTH-bit counter with synchronous clear, enable and terminal-compare input. It outputs the terminal flag and wraps to 0 at terminal.
- Top holds the FSM, config registers and the tick counter.

## Test plan
- Reset then config D=3, N=4, burst, start at cycle 10 -> ticks in cycles 14, 18, 22, 26; `done_o` in 27; `tick_cnt_o`=4; `cfg_ready_o` back high at 28.
- Periodic, D=0, start, stop after 5 cycles -> 5 consecutive ticks, `busy_o` low the cycle after stop, no `done_o`.
- Config offered during RUN -> `cfg_ready_o`=0, stored D unchanged; the same-cycle config+start in IDLE uses the new D=7 (first tick 8 cycles after start).
- Burst N=0 start -> no tick, `done_o` one cycle after start; `rstn_i` low mid-burst (D=2, N=10) -> all outputs reset next cycle, no `done_o`.
- Stop on the edge of the final burst tick (N=2, D=1) -> tick seen, IDLE entered, `done_o` never asserted.
- With `DIV_CTRL_PAUSE_EN`: D=4, pause 3 cycles when prescaler=2 -> next tick delayed exactly 3 cycles, `tick_cnt_o` unchanged during pause.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared types and constants for the div_ctrl tick controller.
//   div_state_e   : controller FSM state encoding
//   MODE_PERIODIC : free-running tick stream until stopped
//   MODE_BURST    : fixed number of ticks followed by a done pulse
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } div_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_BURST    = 1'b1;

endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: valid/ready configuration port of div_ctrl.
//   cfg_valid : config offer (master -> slave)
//   cfg_ready : config accepted when cfg_valid && cfg_ready (slave -> master)
//   cfg_div   : divide value D, tick period D+1 cycles
//   cfg_cnt   : burst length N
//   cfg_mode  : 0 = periodic, 1 = burst
interface div_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_cnt;
  logic             cfg_mode;

  modport master (
    output cfg_valid, cfg_div, cfg_cnt, cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_cnt, cfg_mode,
    output cfg_ready
  );

endinterface

// File: rtl/div_ctrl_prescaler.sv
// div_ctrl_prescaler: WIDTH-bit prescaler counter.
//   clk_i  : clock, rising edge
//   rstn_i : synchronous active-low reset
//   clr_i  : synchronous clear to 0 (priority over en_i)
//   en_i   : count enable
//   term_i : terminal value; the counter wraps to 0 after reaching it
//   term_o : counter currently equals term_i
module div_ctrl_prescaler #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             term_o
);

  logic [WIDTH-1:0] cnt_q;

  assign term_o = (cnt_q == term_i);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= term_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: programmable divide-by-(D+1) tick controller, periodic or burst.
//   clk_i      : clock, rising edge
//   rstn_i     : synchronous active-low reset
//   cfg        : div_ctrl_if.slave config port (D, N, mode); ready only in IDLE
//   start_i    : start request (IDLE only)
//   stop_i     : abort request (RUN/PAUSE only), no done pulse
//   pause_i    : pause request, present only with DIV_CTRL_PAUSE_EN defined
//   tick_o     : one-cycle enable every D+1 RUN cycles
//   busy_o     : high in RUN and PAUSE
//   done_o     : one-cycle pulse at burst completion
//   tick_cnt_o : ticks emitted since the last start
// Optional feature macro: DIV_CTRL_PAUSE_EN (adds pause_i and the PAUSE state).
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  div_ctrl_if.slave        cfg,
  input  logic             start_i,
  input  logic             stop_i,
`ifdef DIV_CTRL_PAUSE_EN
  input  logic             pause_i,
`endif
  output logic             tick_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] tick_cnt_o
);

  div_state_e       state_q;
  logic [WIDTH-1:0] div_q;
  logic [CNT_W-1:0] n_q;
  logic             mode_q;
  logic [CNT_W-1:0] tick_cnt_q;
  logic [CNT_W-1:0] tick_cnt_d;

  logic             cfg_hs;
  logic             start_run;
  logic             term;
  logic             tick;
  logic             pause_req;
  logic [CNT_W-1:0] n_start;
  logic             mode_start;

`ifdef DIV_CTRL_PAUSE_EN
  assign pause_req = pause_i;
`else
  assign pause_req = 1'b0;
`endif

  assign cfg_hs     = cfg.cfg_valid && (state_q == IDLE);
  assign start_run  = (state_q == IDLE) && start_i;
  assign tick       = (state_q == RUN) && term;
  assign tick_cnt_d = tick_cnt_q + 1'b1;

  // A start coinciding with a handshake must see the config being captured.
  assign n_start    = cfg_hs ? cfg.cfg_cnt  : n_q;
  assign mode_start = cfg_hs ? cfg.cfg_mode : mode_q;

  div_ctrl_prescaler #(
    .WIDTH (WIDTH)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (start_run),
    .en_i   (state_q == RUN),
    .term_i (div_q),
    .term_o (term)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      div_q      <= '0;
      n_q        <= '0;
      mode_q     <= MODE_PERIODIC;
      tick_cnt_q <= '0;
    end else begin
      if (cfg_hs) begin
        div_q  <= cfg.cfg_div;
        n_q    <= cfg.cfg_cnt;
        mode_q <= cfg.cfg_mode;
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            tick_cnt_q <= '0;
            state_q    <= (mode_start == MODE_BURST && n_start == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (tick) tick_cnt_q <= tick_cnt_d;
          // stop wins over a burst completing on the same edge
          if (stop_i)
            state_q <= IDLE;
          else if (tick && mode_q == MODE_BURST && tick_cnt_d == n_q)
            state_q <= DONE;
          else if (pause_req)
            state_q <= PAUSE;
        end
        PAUSE: begin
          if (stop_i)
            state_q <= IDLE;
          else if (!pause_req)
            state_q <= RUN;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg.cfg_ready = (state_q == IDLE);
  assign tick_o        = tick;
  assign busy_o        = (state_q == RUN) || (state_q == PAUSE);
  assign done_o        = (state_q == DONE);
  assign tick_cnt_o    = tick_cnt_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed self-checking bench for div_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge. Within each
// scenario j counts cycles after the edge that sampled start_i (j=1 is the
// first RUN cycle). Pause scenario is built only with DIV_CTRL_PAUSE_EN.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        stop;
`ifdef DIV_CTRL_PAUSE_EN
  logic        pause;
`endif
  logic        tick;
  logic        busy;
  logic        done;
  logic [15:0] tcnt;

  int checks = 0;
  int errors = 0;

  div_ctrl_if #(.WIDTH(32), .CNT_W(16)) cfg_if ();

  div_ctrl #(.WIDTH(32), .CNT_W(16)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .cfg        (cfg_if),
    .start_i    (start),
    .stop_i     (stop),
`ifdef DIV_CTRL_PAUSE_EN
    .pause_i    (pause),
`endif
    .tick_o     (tick),
    .busy_o     (busy),
    .done_o     (done),
    .tick_cnt_o (tcnt)
  );

  always #5 clk = ~clk;

  task automatic next_cycle;
    @(negedge clk);
  endtask

  // One config handshake in IDLE, returns at the falling edge after capture.
  task automatic do_cfg(input int unsigned d, input int unsigned n, input logic m);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 32'(d);
    cfg_if.cfg_cnt   = 16'(n);
    cfg_if.cfg_mode  = m;
    next_cycle();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef DIV_CTRL_PAUSE_EN
    pause = 1'b0;
`endif
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_div = '0; cfg_if.cfg_cnt = '0; cfg_if.cfg_mode = 1'b0;
    next_cycle();
    next_cycle();
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset tick_o: got %b want 0", tick); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy_o: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done_o: got %b want 0", done); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset cfg_ready: got %b want 1", cfg_if.cfg_ready); end
    checks++; if (tcnt !== 16'd0) begin errors++; $display("FAIL reset tick_cnt_o: got %0d want 0", tcnt); end
    rstn = 1'b1;
    next_cycle();
  endtask

  // D=3, N=4 burst: ticks at j=4,8,12,16, done at 17, ready again from 18.
  task automatic test_burst;
    int   exp_cnt;
    logic exp_tick;
    do_cfg(3, 4, MODE_BURST);
    start = 1'b1; next_cycle(); start = 1'b0;
    exp_cnt = 0;
    for (int j = 1; j <= 20; j++) begin
      exp_tick = (j == 4) || (j == 8) || (j == 12) || (j == 16);
      checks++; if (tick !== exp_tick) begin errors++; $display("FAIL burst tick_o j=%0d: got %b want %b", j, tick, exp_tick); end
      checks++; if (done !== (j == 17)) begin errors++; $display("FAIL burst done_o j=%0d: got %b want %b", j, done, (j == 17)); end
      checks++; if (busy !== (j <= 16)) begin errors++; $display("FAIL burst busy_o j=%0d: got %b want %b", j, busy, (j <= 16)); end
      checks++; if (cfg_if.cfg_ready !== (j >= 18)) begin errors++; $display("FAIL burst cfg_ready j=%0d: got %b want %b", j, cfg_if.cfg_ready, (j >= 18)); end
      checks++; if (tcnt !== 16'(exp_cnt)) begin errors++; $display("FAIL burst tick_cnt_o j=%0d: got %0d want %0d", j, tcnt, exp_cnt); end
      if (exp_tick) exp_cnt++;
      next_cycle();
    end
  endtask

  // Periodic D=0: tick every cycle, stop after 5 ticks.
  task automatic test_periodic;
    do_cfg(0, 0, MODE_PERIODIC);
    start = 1'b1; next_cycle(); start = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      checks++; if (tick !== 1'b1) begin errors++; $display("FAIL periodic tick_o j=%0d: got %b want 1", j, tick); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL periodic busy_o j=%0d: got %b want 1", j, busy); end
      checks++; if (tcnt !== 16'(j - 1)) begin errors++; $display("FAIL periodic tick_cnt_o j=%0d: got %0d want %0d", j, tcnt, j - 1); end
      if (j == 5) stop = 1'b1;
      next_cycle();
    end
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL periodic busy after stop: got %b want 0", busy); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL periodic tick after stop: got %b want 0", tick); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL periodic done after stop: got %b want 0", done); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL periodic ready after stop: got %b want 1", cfg_if.cfg_ready); end
    checks++; if (tcnt !== 16'd5) begin errors++; $display("FAIL periodic tick_cnt after stop: got %0d want 5", tcnt); end
    next_cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL periodic done late: got %b want 0", done); end
  endtask

  // Same-cycle config+start with D=7, then a D=2 offer during RUN must stall.
  task automatic test_cfg_stall;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 32'd7; cfg_if.cfg_cnt = 16'd0; cfg_if.cfg_mode = MODE_PERIODIC;
    start = 1'b1; next_cycle(); start = 1'b0;
    cfg_if.cfg_div = 32'd2; cfg_if.cfg_mode = MODE_BURST; cfg_if.cfg_cnt = 16'd1;
    for (int j = 1; j <= 17; j++) begin
      checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL stall cfg_ready j=%0d: got %b want 0", j, cfg_if.cfg_ready); end
      checks++; if (tick !== ((j == 8) || (j == 16))) begin errors++; $display("FAIL stall tick_o j=%0d: got %b want %b", j, tick, ((j == 8) || (j == 16))); end
      if (j == 12) cfg_if.cfg_valid = 1'b0;
      if (j == 17) stop = 1'b1;
      next_cycle();
    end
    stop = 1'b0;
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL stall ready after stop: got %b want 1", cfg_if.cfg_ready); end
    // Restart without a handshake: stored D must still be 7.
    start = 1'b1; next_cycle(); start = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      checks++; if (tick !== (j == 8)) begin errors++; $display("FAIL stall stored-D tick_o j=%0d: got %b want %b", j, tick, (j == 8)); end
      if (j == 8) stop = 1'b1;
      next_cycle();
    end
    stop = 1'b0;
  endtask

  // Burst N=0: straight to DONE, no tick, counter cleared.
  task automatic test_burst_zero;
    do_cfg(5, 0, MODE_BURST);
    start = 1'b1; next_cycle(); start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL n0 done_o: got %b want 1", done); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL n0 tick_o: got %b want 0", tick); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL n0 busy_o: got %b want 0", busy); end
    checks++; if (tcnt !== 16'd0) begin errors++; $display("FAIL n0 tick_cnt_o: got %0d want 0", tcnt); end
    next_cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL n0 done second cycle: got %b want 0", done); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL n0 cfg_ready: got %b want 1", cfg_if.cfg_ready); end
  endtask

  // Reset mid-burst (D=2, N=10): outputs and stored config back to reset values.
  task automatic test_reset_mid_burst;
    logic seen_done;
    do_cfg(2, 10, MODE_BURST);
    start = 1'b1; next_cycle(); start = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      checks++; if (tick !== (j == 3)) begin errors++; $display("FAIL rstmid tick_o j=%0d: got %b want %b", j, tick, (j == 3)); end
      next_cycle();
    end
    rstn = 1'b0;
    next_cycle();
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rstmid tick_o: got %b want 0", tick); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy_o: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid done_o: got %b want 0", done); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL rstmid cfg_ready: got %b want 1", cfg_if.cfg_ready); end
    checks++; if (tcnt !== 16'd0) begin errors++; $display("FAIL rstmid tick_cnt_o: got %0d want 0", tcnt); end
    rstn = 1'b1;
    seen_done = 1'b0;
    for (int j = 7; j <= 35; j++) begin
      seen_done |= done;
      next_cycle();
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL rstmid late done_o: got %b want 0", seen_done); end
    // Stored config is now D=0 periodic: tick every cycle.
    start = 1'b1; next_cycle(); start = 1'b0;
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL rstmid cleared-D tick j=1: got %b want 1", tick); end
    next_cycle();
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL rstmid cleared-D tick j=2: got %b want 1", tick); end
    checks++; if (tcnt !== 16'd1) begin errors++; $display("FAIL rstmid cleared-D tick_cnt: got %0d want 1", tcnt); end
    stop = 1'b1; next_cycle(); stop = 1'b0;
  endtask

  // N=2, D=1: stop on the edge of the final tick -> IDLE, never done.
  task automatic test_stop_final;
    do_cfg(1, 2, MODE_BURST);
    start = 1'b1; next_cycle(); start = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      checks++; if (tick !== ((j == 2) || (j == 4))) begin errors++; $display("FAIL stopfin tick_o j=%0d: got %b want %b", j, tick, ((j == 2) || (j == 4))); end
      if (j == 4) stop = 1'b1;
      next_cycle();
    end
    stop = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stopfin done_o: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stopfin busy_o: got %b want 0", busy); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL stopfin cfg_ready: got %b want 1", cfg_if.cfg_ready); end
    checks++; if (tcnt !== 16'd2) begin errors++; $display("FAIL stopfin tick_cnt_o: got %0d want 2", tcnt); end
    next_cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stopfin done late: got %b want 0", done); end
  endtask

`ifdef DIV_CTRL_PAUSE_EN
  // D=4 periodic, pause high for j=8..10 (prescaler 2): tick at 10 moves to 13.
  task automatic test_pause;
    int   exp_cnt;
    logic exp_tick;
    do_cfg(4, 0, MODE_PERIODIC);
    start = 1'b1; next_cycle(); start = 1'b0;
    exp_cnt = 0;
    for (int j = 1; j <= 18; j++) begin
      exp_tick = (j == 5) || (j == 13) || (j == 18);
      checks++; if (tick !== exp_tick) begin errors++; $display("FAIL pause tick_o j=%0d: got %b want %b", j, tick, exp_tick); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pause busy_o j=%0d: got %b want 1", j, busy); end
      checks++; if (tcnt !== 16'(exp_cnt)) begin errors++; $display("FAIL pause tick_cnt_o j=%0d: got %0d want %0d", j, tcnt, exp_cnt); end
      if (exp_tick) exp_cnt++;
      pause = (j >= 8) && (j <= 10);
      next_cycle();
    end
    pause = 1'b0;
    stop = 1'b1; next_cycle(); stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pause busy after stop: got %b want 0", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_burst();
    test_periodic();
    test_cfg_stall();
    test_burst_zero();
    test_reset_mid_burst();
    test_stop_final();
`ifdef DIV_CTRL_PAUSE_EN
    test_pause();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
